trace_line_sequencer: RTL and testbench
=======================================

Name: trace_line_sequencer

Overview:
Controller that reads a stream of 32-bit trace words from a synchronous trace memory. It packs every WORDS_PER_LINE consecutive words into one cache line, with the first word in the most significant slot. Each line is handed to the downstream compressor over a valid/ready handshake. It sits between the trace RAM and the compression engine and handles sequencing, backpressure and zero-padding of a short final line.

Parameters:
ADDR_W, 8, trace memory address width (up to 2^ADDR_W words)
WORD_W, 32, trace word width
WORDS_PER_LINE, 8, words per cache line (line width LINE_W = WORD_W*WORDS_PER_LINE = 256)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a run; sampled only in IDLE
num_words  in  ADDR_W+1  word count for the run, latched on start
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at end of run
mem_rd_en  out  1  read strobe to trace memory
mem_addr  out  ADDR_W  read address; memory returns data one cycle later
mem_rdata  in  WORD_W  read data, valid the cycle after mem_rd_en
line_valid  out  1  line_data holds a complete line
line_ready  in  1  downstream accepts the line
line_data  out  LINE_W  packed line; word 0 at [LINE_W-1 -: WORD_W]
line_last  out  1  qualifies the final line of the run
line_idx  out  ADDR_W  index of the current line within the run, starting at 0

Behaviour:
- Reset, asynchronous: state IDLE; busy, done, mem_rd_en, line_valid, line_last = 0; mem_addr, line_data, line_idx and all counters = 0. Assertion mid-run aborts the run immediately; no done pulse is generated.
- Decided interface: one clock (clk); reset is asynchronous and active-high (rst).
- States: IDLE, READ, DRAIN, PAD, OUT, FIN.
- IDLE, start=1 and num_words>0: latch num_words, set addr=0, clear line_idx, go to READ.
- IDLE, start=1 and num_words=0: go to FIN; no lines are emitted.
- start is ignored outside IDLE.
- READ: mem_rd_en=1 and mem_addr=addr each cycle; addr increments each cycle.
  - Stays for n = min(WORDS_PER_LINE, remaining) cycles, then goes to DRAIN.
  - The packer shifts left by WORD_W and inserts mem_rdata at the LSB, one cycle after each read.
- DRAIN: captures the last word; goes to PAD if n<WORDS_PER_LINE, else to OUT.
- PAD: shifts in zero words for WORDS_PER_LINE-n cycles, then goes to OUT. A partial line therefore has its valid words in the top slots and zeros in the bottom slots.
- OUT: line_valid=1.
  - line_data, line_last and line_idx are held stable while line_ready=0.
  - On valid&&ready: line_idx increments; go to READ if words remain, else to FIN.
- FIN: done=1 for one cycle, busy=0 from that cycle onward, return to IDLE.
- Latency with no stall: start sampled at edge E0 gives line_valid high after edge E9. Each later line's line_valid follows 9 edges after the previous handshake. There is no prefetch overlap with OUT.
- Addresses wrap modulo 2^ADDR_W. num_words > 2^ADDR_W therefore rereads from address 0.
- line_last = 1 only on the final line, including when that line is full.

Optional Feature:
LINE_STATS_EN
- Defined: adds outputs stat_lines[15:0] and stat_zero_lines[15:0].
  - stat_lines counts accepted lines; stat_zero_lines counts accepted lines whose line_data is all zero.
  - Both clear on an accepted start and on rst, and saturate at 16'hFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package trace_pkg holds:
  - WORD_W, WORDS_PER_LINE, LINE_W;
  - the state enum (IDLE, READ, DRAIN, PAD, OUT, FIN);
  - a function returning the slot range of word k within a line.
- One sub-module, line_packer: LINE_W shift register with shift_en, a shift_in word and a clear input. The FSM stays in trace_line_sequencer.

Test Plan:
- Full run: memory word k = 32'h1000_0000+k, num_words=16, line_ready=1 → 2 lines.
  - Line 0 = {10000000,...,10000007} with first valid after E9.
  - Line 1 ends in 1000000F with line_last=1 and line_idx=1; done pulses once.
- Partial line: num_words=11 → line 1 = {words 8,9,10, then five zero words} with line_last=1; exactly 11 mem_rd_en pulses.
- Backpressure: hold line_ready=0 for 5 cycles in OUT → line_data stable, no mem_rd_en until the handshake, then the next line follows 9 edges later.
- Zero count and ignored start: num_words=0 → done pulse, no line_valid. start pulsed while busy → no effect on the run.
- Reset mid-run: assert rst during PAD → all outputs 0 immediately; a new start runs cleanly from address 0.
- LINE_STATS_EN: 24-word run where words 8..15 are zero → stat_lines=3, stat_zero_lines=1.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared constants, FSM state type and line slot helper for trace_line_sequencer.
package trace_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned WORDS_PER_LINE = 8;
  localparam int unsigned LINE_W         = WORD_W * WORDS_PER_LINE;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    PAD,
    OUT,
    FIN
  } state_e;

  typedef struct packed {
    logic [7:0] msb;
    logic [7:0] lsb;
  } slot_range_t;

  // Bit range of word k inside a line; word 0 occupies the top slot.
  function automatic slot_range_t slot_range(input int unsigned k);
    slot_range_t r;
    r.msb = 8'(LINE_W - 1 - k * WORD_W);
    r.lsb = 8'(LINE_W - (k + 1) * WORD_W);
    return r;
  endfunction

endpackage

// File: rtl/line_packer.sv
// Line-wide shift register: each shift moves the line up one word and inserts at the LSB.
module line_packer
  import trace_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              shift_en_i,
  input  logic [WORD_W-1:0] shift_in_i,
  output logic [LINE_W-1:0] line_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_o <= '0;
    end else if (clear_i) begin
      line_o <= '0;
    end else if (shift_en_i) begin
      line_o <= {line_o[LINE_W-WORD_W-1:0], shift_in_i};
    end
  end

endmodule

// File: rtl/trace_line_sequencer.sv
// Reads trace words from a 1-cycle-latency RAM and emits zero-padded cache lines over valid/ready.
// Optional macro LINE_STATS_EN adds stat_lines / stat_zero_lines counters.
module trace_line_sequencer
  import trace_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              line_valid,
  input  logic              line_ready,
  output logic [LINE_W-1:0] line_data,
  output logic              line_last,
  output logic [ADDR_W-1:0] line_idx
`ifdef LINE_STATS_EN
  ,
  output logic [15:0]       stat_lines,
  output logic [15:0]       stat_zero_lines
`endif
);

  localparam int unsigned NUM_W = ADDR_W + 1;
  localparam int unsigned CNT_W = $clog2(WORDS_PER_LINE) + 1;
  localparam logic [CNT_W-1:0] FULL_N = CNT_W'(WORDS_PER_LINE);

  state_e            state_q;
  logic [NUM_W-1:0]  rem_q;
  logic [CNT_W-1:0]  n_q;
  logic [CNT_W-1:0]  slot_q;
  logic              rd_vld_q;

  logic              start_ok_c;
  logic              accept_c;
  logic              pk_shift_c;
  logic [WORD_W-1:0] pk_in_c;

  function automatic logic [CNT_W-1:0] line_len(input logic [NUM_W-1:0] cnt);
    if (cnt >= NUM_W'(WORDS_PER_LINE)) return FULL_N;
    return CNT_W'(cnt);
  endfunction

  assign start_ok_c = (state_q == IDLE) && start;
  assign accept_c   = line_valid && line_ready;
  // rd_vld_q marks the cycle in which the RAM presents the word read last cycle.
  assign pk_shift_c = rd_vld_q || (state_q == PAD);
  assign pk_in_c    = rd_vld_q ? mem_rdata : '0;

  line_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (start_ok_c),
    .shift_en_i (pk_shift_c),
    .shift_in_i (pk_in_c),
    .line_o     (line_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      n_q        <= '0;
      slot_q     <= '0;
      rd_vld_q   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      line_valid <= 1'b0;
      line_last  <= 1'b0;
      line_idx   <= '0;
    end else begin
      rd_vld_q <= mem_rd_en;
      done     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (num_words != '0) begin
              state_q   <= READ;
              busy      <= 1'b1;
              rem_q     <= num_words;
              n_q       <= line_len(num_words);
              slot_q    <= '0;
              mem_addr  <= '0;
              mem_rd_en <= 1'b1;
              line_idx  <= '0;
            end else begin
              state_q <= FIN;
              done    <= 1'b1;
            end
          end
        end
        READ: begin
          mem_addr <= mem_addr + ADDR_W'(1);
          rem_q    <= rem_q - NUM_W'(1);
          slot_q   <= slot_q + CNT_W'(1);
          if (slot_q == n_q - CNT_W'(1)) begin
            mem_rd_en <= 1'b0;
            state_q   <= DRAIN;
          end
        end
        DRAIN: begin
          if (n_q != FULL_N) begin
            state_q <= PAD;
          end else begin
            state_q    <= OUT;
            line_valid <= 1'b1;
            line_last  <= (rem_q == '0);
          end
        end
        PAD: begin
          slot_q <= slot_q + CNT_W'(1);
          if (slot_q == FULL_N - CNT_W'(1)) begin
            state_q    <= OUT;
            line_valid <= 1'b1;
            line_last  <= (rem_q == '0);
          end
        end
        OUT: begin
          if (line_ready) begin
            line_valid <= 1'b0;
            line_last  <= 1'b0;
            line_idx   <= line_idx + ADDR_W'(1);
            if (rem_q != '0) begin
              state_q   <= READ;
              mem_rd_en <= 1'b1;
              n_q       <= line_len(rem_q);
              slot_q    <= '0;
            end else begin
              state_q <= FIN;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef LINE_STATS_EN
  // Saturating counters of accepted lines and of accepted all-zero lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lines      <= '0;
      stat_zero_lines <= '0;
    end else if (start_ok_c) begin
      stat_lines      <= '0;
      stat_zero_lines <= '0;
    end else if (accept_c) begin
      if (stat_lines != 16'hFFFF) stat_lines <= stat_lines + 16'd1;
      if ((line_data == '0) && (stat_zero_lines != 16'hFFFF)) begin
        stat_zero_lines <= stat_zero_lines + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_trace_line_sequencer.sv
// Self-checking bench for trace_line_sequencer with a behavioural line model and RAM model.
module tb_trace_line_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [8:0]   num_words = '0;
  logic         busy, done, mem_rd_en, line_valid, line_last;
  logic         line_ready = 1'b0;
  logic [7:0]   mem_addr, line_idx;
  logic [31:0]  mem_rdata = '0;
  logic [255:0] line_data;
`ifdef LINE_STATS_EN
  logic [15:0]  stat_lines, stat_zero_lines;
`endif

  trace_line_sequencer #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_words  (num_words),
    .busy       (busy),
    .done       (done),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .line_data  (line_data),
    .line_last  (line_last),
    .line_idx   (line_idx)
`ifdef LINE_STATS_EN
    ,
    .stat_lines      (stat_lines),
    .stat_zero_lines (stat_zero_lines)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  int n_checks = 0;
  int n_pass = 0;

  logic [255:0] got_data[$];
  bit           got_last[$];
  int           got_idx[$], rise_t[$], hs_t[$], addr_log[$];
  int           rd_cnt, done_cnt, stab_err, rd_in_out, busy_err;
  bit           timed_out;

  // Expected line l of an n-word run: words l*8.. in top-down slots, zeros past the end.
  function automatic logic [255:0] exp_line(input int l, input int n);
    logic [255:0] v;
    trace_pkg::slot_range_t r;
    v = '0;
    for (int s = 0; s < 8; s++) begin
      if (l * 8 + s < n) begin
        r = trace_pkg::slot_range(s);
        v[r.lsb +: 32] = mem[(l * 8 + s) % 256];
      end
    end
    return v;
  endfunction

  // Drives one run and records lines, handshakes, reads and protocol violations.
  task automatic run(input int n, input int mode, input bit poke, input int max_cyc);
    int t, stall, done_t;
    logic [255:0] hd;
    bit hl, r, pv;
    int hi;
    got_data.delete(); got_last.delete(); got_idx.delete();
    rise_t.delete(); hs_t.delete(); addr_log.delete();
    rd_cnt = 0; done_cnt = 0; stab_err = 0; rd_in_out = 0; busy_err = 0;
    timed_out = 0; done_t = -1; pv = 0; stall = 0; hd = '0; hl = 0; hi = 0;
    @(negedge clk); start = 1'b1; num_words = 9'(n);
    @(negedge clk); start = 1'b0; t = 0;
    while (1) begin
      if (t >= max_cyc) begin timed_out = 1; break; end
      if (done_t >= 0 && t > done_t + 3) break;
      start = poke && (t == 5 || t == 15);
      if (start) num_words = 9'd3;
      if (mem_rd_en) begin rd_cnt++; addr_log.push_back(int'(mem_addr)); end
      if (done) begin
        done_cnt++;
        if (done_t < 0) done_t = t;
        if (busy) busy_err++;
      end else if (done_t < 0 && n > 0 && !busy) busy_err++;
      if (line_valid) begin
        if (!pv) begin
          rise_t.push_back(t); hd = line_data; hl = line_last; hi = int'(line_idx); stall = 0;
        end else if (line_data !== hd || line_last !== hl || int'(line_idx) !== hi) stab_err++;
        if (mem_rd_en) rd_in_out++;
        case (mode)
          0: r = 1'b1;
          1: r = ($urandom_range(0, 2) != 0);
          default: r = (stall >= 5);
        endcase
        stall++;
        if (r) begin
          got_data.push_back(line_data); got_last.push_back(line_last);
          got_idx.push_back(int'(line_idx)); hs_t.push_back(t);
        end
        pv = !r;
      end else begin
        r = 1'($urandom_range(0, 1));
        pv = 0;
      end
      line_ready = r;
      @(negedge clk); t++;
    end
    start = 1'b0;
    line_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({busy, done, mem_rd_en, line_valid, line_last} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {busy, done, mem_rd_en, line_valid, line_last});
    else n_pass++;
    n_checks++;
    if (mem_addr !== 8'd0 || line_idx !== 8'd0)
      $display("FAIL reset_addr_idx: got %0h/%0h want 0/0", mem_addr, line_idx);
    else n_pass++;
    n_checks++;
    if (line_data !== 256'd0) $display("FAIL reset_data: got %0h want 0", line_data);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_run();
    for (int k = 0; k < 256; k++) mem[k] = 32'h1000_0000 + 32'(k);
    run(16, 0, 0, 400);
    n_checks++;
    if (timed_out || got_data.size() != 2)
      $display("FAIL full_lines: got %0d lines (timeout %0d) want 2", got_data.size(), timed_out);
    else n_pass++;
    if (got_data.size() == 2) begin
      n_checks++;
      if (got_data[0] !== exp_line(0, 16) || got_data[0][255 -: 32] !== 32'h1000_0000)
        $display("FAIL full_line0: got %0h want %0h", got_data[0], exp_line(0, 16));
      else n_pass++;
      n_checks++;
      if (got_data[1] !== exp_line(1, 16) || got_data[1][31:0] !== 32'h1000_000F)
        $display("FAIL full_line1: got %0h want %0h", got_data[1], exp_line(1, 16));
      else n_pass++;
      n_checks++;
      if ({got_last[0], got_last[1]} !== 2'b01 || got_idx[0] !== 0 || got_idx[1] !== 1)
        $display("FAIL full_last_idx: got last %b%b idx %0d,%0d want 01 0,1",
                 got_last[0], got_last[1], got_idx[0], got_idx[1]);
      else n_pass++;
      n_checks++;
      if (rise_t[0] !== 9 || rise_t[1] !== 19)
        $display("FAIL full_latency: got %0d,%0d want 9,19", rise_t[0], rise_t[1]);
      else n_pass++;
    end
    n_checks++;
    if (done_cnt !== 1 || rd_cnt !== 16 || busy_err !== 0)
      $display("FAIL full_done_reads: got done %0d reads %0d busyerr %0d want 1 16 0",
               done_cnt, rd_cnt, busy_err);
    else n_pass++;
  endtask

  task automatic test_partial();
    logic [255:0] want;
    want = {32'h1000_0008, 32'h1000_0009, 32'h1000_000A, 160'd0};
    run(11, 0, 0, 400);
    n_checks++;
    if (timed_out || got_data.size() != 2 || rd_cnt !== 11)
      $display("FAIL partial_count: got %0d lines %0d reads want 2 11", got_data.size(), rd_cnt);
    else n_pass++;
    if (got_data.size() == 2) begin
      n_checks++;
      if (got_data[1] !== want || got_last[1] !== 1'b1 || got_last[0] !== 1'b0)
        $display("FAIL partial_line1: got %0h last %b want %0h last 1",
                 got_data[1], got_last[1], want);
      else n_pass++;
      n_checks++;
      if (rise_t[1] !== hs_t[0] + 10)
        $display("FAIL partial_timing: got %0d want %0d", rise_t[1], hs_t[0] + 10);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int e;
    for (int k = 0; k < 256; k++) mem[k] = $urandom;
    run(20, 2, 0, 600);
    n_checks++;
    if (timed_out || stab_err !== 0 || rd_in_out !== 0)
      $display("FAIL bp_stable: got stab %0d rd_in_out %0d timeout %0d want 0 0 0",
               stab_err, rd_in_out, timed_out);
    else n_pass++;
    e = 0;
    if (got_data.size() != 3 || hs_t[0] !== 14) e++;
    for (int l = 0; l < got_data.size(); l++) begin
      if (got_data[l] !== exp_line(l, 20) || got_last[l] !== (l == 2)) e++;
      if (l > 0 && rise_t[l] !== hs_t[l-1] + 10) e++;
    end
    n_checks++;
    if (e !== 0) $display("FAIL bp_lines: got %0d errors want 0", e);
    else n_pass++;
  endtask

  task automatic test_zero_and_ignore();
    run(0, 0, 0, 50);
    n_checks++;
    if (timed_out || done_cnt !== 1 || got_data.size() != 0 || rd_cnt !== 0 || rise_t.size() != 0)
      $display("FAIL zero_count: got done %0d lines %0d reads %0d want 1 0 0",
               done_cnt, got_data.size(), rd_cnt);
    else n_pass++;
    for (int k = 0; k < 256; k++) mem[k] = $urandom;
    run(12, 0, 1, 400);
    n_checks++;
    if (timed_out || got_data.size() != 2 || rd_cnt !== 12 || done_cnt !== 1)
      $display("FAIL ignore_start_count: got %0d lines %0d reads %0d done want 2 12 1",
               got_data.size(), rd_cnt, done_cnt);
    else n_pass++;
    if (got_data.size() == 2) begin
      n_checks++;
      if (got_data[0] !== exp_line(0, 12) || got_data[1] !== exp_line(1, 12))
        $display("FAIL ignore_start_data: got %0h want %0h", got_data[1], exp_line(1, 12));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int n, nl, e;
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 256; k++) mem[k] = $urandom;
      n = $urandom_range(1, 40);
      nl = (n + 7) / 8;
      run(n, 1, 0, 3000);
      e = 0;
      if (timed_out || got_data.size() != nl || rd_cnt !== n || done_cnt !== 1) e++;
      if (stab_err !== 0 || rd_in_out !== 0 || busy_err !== 0) e++;
      for (int l = 0; l < got_data.size(); l++) begin
        if (got_data[l] !== exp_line(l, n) || got_last[l] !== (l == nl - 1) || got_idx[l] !== l) e++;
        if ((l == 0 && rise_t[0] !== 9) || (l > 0 && rise_t[l] !== hs_t[l-1] + 10)) e++;
      end
      n_checks++;
      if (e !== 0) $display("FAIL random_run n=%0d: got %0d errors want 0", n, e);
      else n_pass++;
    end
    run(260, 0, 0, 1000);
    e = 0;
    if (timed_out || addr_log.size() != 260 || got_data.size() != 33) e++;
    for (int i = 0; i < addr_log.size(); i++) if (addr_log[i] !== i % 256) e++;
    if (got_data.size() == 33 && (got_data[32] !== exp_line(32, 260) || got_last[32] !== 1'b1)) e++;
    n_checks++;
    if (e !== 0) $display("FAIL wrap_run: got %0d errors want 0", e);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk); start = 1'b1; num_words = 9'd11;
    @(negedge clk); start = 1'b0; line_ready = 1'b1;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, mem_rd_en, line_valid, line_last} !== 5'b0 || mem_addr !== 8'd0 ||
        line_idx !== 8'd0 || line_data !== 256'd0)
      $display("FAIL midreset_outputs: got ctrl %b addr %0h idx %0h data %0h want all 0",
               {busy, done, mem_rd_en, line_valid, line_last}, mem_addr, line_idx, line_data);
    else n_pass++;
    @(negedge clk); rst = 1'b0; line_ready = 1'b0;
    run(16, 0, 0, 400);
    n_checks++;
    if (timed_out || got_data.size() != 2 || addr_log.size() == 0 || addr_log[0] !== 0 ||
        got_data[0] !== exp_line(0, 16) || rise_t[0] !== 9)
      $display("FAIL midreset_rerun: got %0d lines first addr %0d want 2 lines addr 0",
               got_data.size(), (addr_log.size() > 0) ? addr_log[0] : -1);
    else n_pass++;
  endtask

`ifdef LINE_STATS_EN
  task automatic test_stats();
    for (int k = 0; k < 256; k++) mem[k] = (k >= 8 && k < 16) ? 32'd0 : 32'(k + 1);
    run(24, 1, 0, 1000);
    n_checks++;
    if (timed_out || stat_lines !== 16'd3 || stat_zero_lines !== 16'd1)
      $display("FAIL stats: got %0d/%0d want 3/1", stat_lines, stat_zero_lines);
    else n_pass++;
  endtask
`endif

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'd0;
    repeat (2) @(negedge clk);
    test_reset();
    test_full_run();
    test_partial();
    test_backpressure();
    test_zero_and_ignore();
    test_random();
    test_reset_mid();
`ifdef LINE_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
